// File: rtl/exec_pkg.sv
// Shared opcodes, FSM encoding and immediate-extension helpers for the execute pipe.
// EXEC_DIV_EN (optional macro) enables the iterative divider in the execute pipe.
package exec_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_LUI   = 5'd10;
    localparam logic [4:0] OP_SLL   = 5'd11;
    localparam logic [4:0] OP_SRL   = 5'd12;
    localparam logic [4:0] OP_SRA   = 5'd13;
    localparam logic [4:0] OP_SLLV  = 5'd14;
    localparam logic [4:0] OP_SRLV  = 5'd15;
    localparam logic [4:0] OP_SRAV  = 5'd16;
    localparam logic [4:0] OP_MFHI  = 5'd17;
    localparam logic [4:0] OP_MFLO  = 5'd18;
    localparam logic [4:0] OP_MULT  = 5'd19;
    localparam logic [4:0] OP_MULTU = 5'd20;
    localparam logic [4:0] OP_DIV   = 5'd21;
    localparam logic [4:0] OP_DIVU  = 5'd22;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Extended to 64 bits; callers truncate to their datapath width.
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    function automatic logic [63:0] zext16(input logic [15:0] v);
        return {48'h0, v};
    endfunction

endpackage

// File: rtl/exec_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for W cycles.
// Divider datapath present only when EXEC_DIV_EN is defined.
module exec_muldiv_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sgn,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W);

    logic         run;
    logic [CW-1:0] cnt;
    logic         neg_q;
    logic [W-1:0] acc_hi, acc_lo, opnd;
    logic [W-1:0] nxt_hi, nxt_lo;
    logic         neg_a, neg_b;
    logic [W-1:0] mag_a, mag_b;
    logic [W:0]   msum;
    logic [2*W-1:0] prod;

    assign neg_a = sgn & a[W-1];
    assign neg_b = sgn & b[W-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    // Multiply: {acc_hi,acc_lo} starts as {0,|a|}; conditional add of |b| then shift right.
    assign msum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef EXEC_DIV_EN
    logic         div_r, dz, neg_r;
    logic [W-1:0] a_orig;
    logic [W:0]   rs, trial;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign rs    = {acc_hi, acc_lo[W-1]};
    assign trial = rs - {1'b0, opnd};

    always_comb begin
        if (div_r) begin
            nxt_hi = trial[W] ? rs[W-1:0] : trial[W-1:0];
            nxt_lo = {acc_lo[W-2:0], ~trial[W]};
        end else begin
            nxt_hi = msum[W:1];
            nxt_lo = {msum[0], acc_lo[W-1:1]};
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
    assign nxt_hi = msum[W:1];
    assign nxt_lo = {msum[0], acc_lo[W-1:1]};
`endif

    assign done = run & (cnt == CW'(W - 1));
    assign prod = {nxt_hi, nxt_lo};

    // Results are taken from the final step's next-state so done needs no extra cycle.
    always_comb begin
        {hi, lo} = neg_q ? -prod : prod;
`ifdef EXEC_DIV_EN
        if (div_r) begin
            if (dz) begin
                lo = '1;
                hi = a_orig;
            end else begin
                lo = neg_q ? -nxt_lo : nxt_lo;
                hi = neg_r ? -nxt_hi : nxt_hi;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
`ifdef EXEC_DIV_EN
            div_r  <= 1'b0;
            dz     <= 1'b0;
            neg_r  <= 1'b0;
            a_orig <= '0;
`endif
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            neg_q  <= neg_a ^ neg_b;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
`ifdef EXEC_DIV_EN
            div_r  <= is_div;
            dz     <= (b == '0);
            neg_r  <= neg_a;
            a_orig <= a;
`endif
        end else if (run) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_pipe_unit.sv
// Pipelined execute stage: registered ALU/shift/EA results with valid/ready handshakes and HI/LO.
// Define EXEC_DIV_EN to execute DIV/DIVU; otherwise they retire at once as illegal.
module execute_pipe_unit
    import exec_pkg::*;
#(
    parameter int W    = 32,
    parameter int SH_W = $clog2(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [15:0]     imm,
    input  logic            use_imm,
    input  logic [SH_W-1:0] sa,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result,
    output logic [W-1:0]    ea,
    output logic [W-1:0]    dm_in,
    output logic            ovf,
    output logic            illegal,
    output logic            busy
);
    logic [1:0]      state;
    logic [W-1:0]    hi_r, lo_r;
    logic [W-1:0]    imm_s, imm_z, opb, sum, diff, lui_val, alu_res;
    logic [SH_W-1:0] vsh;
    logic            alu_ovf, alu_ill, logic_op;
    logic            is_mul, is_div_op, multi, md_signed, accept, start, slot_free;
    logic            md_done;
    logic [W-1:0]    md_hi, md_lo;

    assign imm_s    = W'(sext16(imm));
    assign imm_z    = W'(zext16(imm));
    assign logic_op = (op == OP_AND) | (op == OP_OR) | (op == OP_XOR);
    assign opb      = use_imm ? (logic_op ? imm_z : imm_s) : b;
    assign sum      = a + opb;
    assign diff     = a - opb;
    assign lui_val  = W'({imm, 16'h0000});
    assign vsh      = a[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == opb[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[W-1] != opb[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_SUBU:  alu_res = diff;
            OP_AND:   alu_res = a & opb;
            OP_OR:    alu_res = a | opb;
            OP_XOR:   alu_res = a ^ opb;
            OP_NOR:   alu_res = ~(a | opb);
            OP_SLT:   alu_res[0] = $signed(a) < $signed(opb);
            OP_SLTU:  alu_res[0] = a < opb;
            OP_LUI:   alu_res = lui_val;
            OP_SLL:   alu_res = b << sa;
            OP_SRL:   alu_res = b >> sa;
            OP_SRA:   alu_res = $unsigned($signed(b) >>> sa);
            OP_SLLV:  alu_res = b << vsh;
            OP_SRLV:  alu_res = b >> vsh;
            OP_SRAV:  alu_res = $unsigned($signed(b) >>> vsh);
            OP_MFHI:  alu_res = hi_r;
            OP_MFLO:  alu_res = lo_r;
            OP_MULT, OP_MULTU: ;
`ifdef EXEC_DIV_EN
            OP_DIV, OP_DIVU: ;
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

    assign is_mul    = (op == OP_MULT) | (op == OP_MULTU);
`ifdef EXEC_DIV_EN
    assign is_div_op = (op == OP_DIV) | (op == OP_DIVU);
`else
    assign is_div_op = 1'b0;
`endif
    assign multi     = is_mul | is_div_op;
    assign md_signed = (op == OP_MULT) | (op == OP_DIV);
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = (state == ST_IDLE) & slot_free;
    assign accept    = in_valid & in_ready;
    assign start     = accept & multi;
    assign busy      = (state == ST_MUL) | (state == ST_DIV);

    exec_muldiv_seq #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sgn    (md_signed),
        .is_div (is_div_op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= is_mul ? ST_MUL : ST_DIV;
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        hi_r  <= md_hi;
                        lo_r  <= md_lo;
                        state <= ST_DONE;
                    end
                end
                default: if (slot_free) state <= ST_IDLE;
            endcase
        end
    end

    // Completion beat and single-cycle beats never collide: in_ready is low outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            ea        <= '0;
            dm_in     <= '0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if ((state == ST_DONE) && slot_free) begin
            out_valid <= 1'b1;
            result    <= lo_r;
            ea        <= '0;
            dm_in     <= '0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !multi) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            ea        <= a + imm_s;
            dm_in     <= b;
            ovf       <= alu_ovf;
            illegal   <= alu_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            ea        <= '0;
            dm_in     <= '0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe_unit.sv
// Directed scoreboard bench for execute_pipe_unit; expectations follow EXEC_DIV_EN if defined.
module tb_execute_pipe_unit;
    import exec_pkg::*;

    localparam int W    = 32;
    localparam int SH_W = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = '0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [15:0]     imm = '0;
    logic            use_imm = 1'b0;
    logic [SH_W-1:0] sa = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    result, ea, dm_in;
    logic            ovf, illegal, busy;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         ill;
        logic         chk_ea;
        logic [W-1:0] ea;
        logic [W-1:0] dm;
        logic [63:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t got;
    int   total = 0;
    int   bad = 0;

    execute_pipe_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .use_imm   (use_imm),
        .sa        (sa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ea        (ea),
        .dm_in     (dm_in),
        .ovf       (ovf),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Consumer side: pop one expectation per beat taken by downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk({$sformatf("%0s", got.tag), "_res"}, result, got.res);
                chk({$sformatf("%0s", got.tag), "_ovf"}, ovf, got.ovf);
                chk({$sformatf("%0s", got.tag), "_ill"}, illegal, got.ill);
                if (got.chk_ea) begin
                    chk({$sformatf("%0s", got.tag), "_ea"}, ea, got.ea);
                    chk({$sformatf("%0s", got.tag), "_dm"}, dm_in, got.dm);
                end
            end
        end
    end

    task automatic drive(input logic [4:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [15:0] ii, input logic ui, input logic [SH_W-1:0] s,
                         input logic [W-1:0] er, input logic eo, input logic el,
                         input logic ce, input logic [63:0] tg);
        op = o; a = aa; b = bb; imm = ii; use_imm = ui; sa = s; in_valid = 1'b1;
        cur.res = er; cur.ovf = eo; cur.ill = el; cur.chk_ea = ce;
        cur.ea = aa + {{16{ii[15]}}, ii};
        cur.dm = bb;
        cur.tag = tg;
    endtask

    task automatic wait_acc();
        bit acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(cur);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [15:0] ii, input logic ui, input logic [SH_W-1:0] s,
                         input logic [W-1:0] er, input logic eo, input logic el,
                         input logic ce, input logic [63:0] tg);
        drive(o, aa, bb, ii, ui, s, er, eo, el, ce, tg);
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid || !in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", 64'(n < 300), 64'd1);
    endtask

    task automatic busy_run(input logic [63:0] tg);
        int n = 0;
        do begin
            @(negedge clk);
            if (n == 0) chk("in_ready_busy", in_ready, 1'b0);
            if (busy) n++;
        end while (busy && n < 100);
        chk({$sformatf("%0s", tg), "_busy_cycles"}, 64'(n), 64'(W));
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        issue(OP_ADD,  32'h7FFF_FFFF, 32'h1, 16'h0, 1'b0, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, "ADD");
        issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 16'h0, 1'b0, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "ADDU");
        issue(OP_SUB,  32'h8000_0000, 32'h1, 16'h0, 1'b0, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, "SUB");
        issue(OP_AND,  32'hFFFF_FFFF, 32'h0, 16'h8000, 1'b1, 5'd0, 32'h0000_8000, 1'b0, 1'b0, 1'b1, "ANDI");
        issue(OP_ADD,  32'h0, 32'h5, 16'hFFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "ADDI");
        issue(OP_XOR,  32'h0000_FFFF, 32'h0, 16'hF0F0, 1'b1, 5'd0, 32'h0000_0F0F, 1'b0, 1'b0, 1'b1, "XORI");
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0, 1'b1, "SLT");
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, "SLTU");
        issue(OP_LUI,  32'h0, 32'h0, 16'h1234, 1'b1, 5'd0, 32'h1234_0000, 1'b0, 1'b0, 1'b1, "LUI");
        issue(OP_SRA,  32'h0, 32'h8000_0000, 16'h0, 1'b0, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b1, "SRA");
        issue(OP_SLLV, 32'd35, 32'h1, 16'h0, 1'b0, 5'd0, 32'h8, 1'b0, 1'b0, 1'b1, "SLLV");
        issue(OP_SRL,  32'h0, 32'h8000_0000, 16'h0, 1'b0, 5'd31, 32'h1, 1'b0, 1'b0, 1'b1, "SRL");
        issue(OP_NOR,  32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "NOR");
        issue(5'd31,   32'h1234, 32'h5678, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, "UNDEF");
        drain();

        out_ready = 1'b0;
        issue(OP_ADD, 32'd5, 32'd6, 16'h0, 1'b0, 5'd0, 32'd11, 1'b0, 1'b0, 1'b1, "BP_A");
        drive(OP_SUB, 32'd10, 32'd3, 16'h0, 1'b0, 5'd0, 32'd7, 1'b0, 1'b0, 1'b1, "BP_B");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_hold", result, 32'd11);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_acc();
        @(negedge clk);
        chk("bp_no_bubble", out_valid, 1'b1);
        @(posedge clk); #1;
        drain();

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, "MULT");
        busy_run("MULT");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "MFHI1");
        issue(OP_MFLO, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b1, "MFLO1");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0, "MULTU");
        busy_run("MULTU");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, "MFHI2");
        drain();

`ifdef EXEC_DIV_EN
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, "DIV");
        busy_run("DIV");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, "MFHI3");
        issue(OP_DIV, 32'd5, 32'd0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "DIVZ");
        busy_run("DIVZ");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'd5, 1'b0, 1'b0, 1'b1, "MFHI4");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0, 1'b0, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "DIVMN");
        busy_run("DIVMN");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, "MFHI5");
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 16'h0, 1'b0, 5'd0, 32'h7FFF_FFFC, 1'b0, 1'b0, 1'b0, "DIVU");
        busy_run("DIVU");
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0, 1'b1, "MFHI6");
`else
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, "DIV");
        issue(OP_DIVU, 32'd5, 32'd0, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, "DIVU");
        @(negedge clk);
        chk("div_no_busy", busy, 1'b0);
        @(posedge clk); #1;
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, "MFHI3");
        issue(OP_MFLO, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0, 1'b1, "MFLO3");
`endif
        drain();

        issue(OP_MULT, 32'd3, 32'd7, 16'h0, 1'b0, 5'd0, 32'd21, 1'b0, 1'b0, 1'b0, "MULT_RST");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_result", result, '0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        issue(OP_MFHI, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, "RST_HI");
        issue(OP_MFLO, 32'h0, 32'h0, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, "RST_LO");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
